// File: rtl/multi_actuator_pkg.sv
// multi_actuator_pkg: register offsets, channel state encoding and default version
package multi_actuator_pkg;
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_DONE    = 3'd2;
    localparam logic [2:0] REG_ERR     = 3'd3;
    localparam logic [2:0] REG_IRQ_EN  = 3'd4;
    localparam logic [2:0] REG_TIMEOUT = 3'd5;
    localparam logic [2:0] REG_ABORT   = 3'd6;
    localparam logic [2:0] REG_VERSION = 3'd7;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [31:0] VERSION_DEFAULT = 32'h0001_0002;
endpackage

// File: rtl/multi_actuator_if.sv
// multi_actuator_if: Avalon-MM slave bus (address, write_n, read_n, writedata, readdata)
interface multi_actuator_if #(parameter int DATA_W = 32);
    logic [2:0]        address;
    logic              write_n;
    logic              read_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    modport master(output address, write_n, read_n, writedata, input readdata);
    modport slave(input address, write_n, read_n, writedata, output readdata);
endinterface

// File: rtl/multi_actuator_channel.sv
// actuator_channel: one IDLE/RUN channel with watchdog; ports clk, reset, start, abort, done, timeout -> en, done_set, err_set
module actuator_channel
    import multi_actuator_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             done,
    input  logic [CNT_W-1:0] timeout,
    output logic             en,
    output logic             done_set,
    output logic             err_set
);
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             expire;
    assign en       = state == RUN;
    assign expire   = timeout != '0 && cnt == timeout - CNT_W'(1);
    assign done_set = en & done;
    assign err_set  = en & ~done & ~abort & expire;
    // exit priority is done > abort > watchdog; counter saturates at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= en ? ((done | abort | expire) ? IDLE : RUN) : (start ? RUN : IDLE);
            cnt   <= en ? cnt + CNT_W'(~&cnt) : '0;
        end
    end
endmodule

// File: rtl/multi_actuator.sv
// multi_actuator: multi-channel start/done controller; ports clk, reset, bus (Avalon slave), done -> en, irq
module multi_actuator
    import multi_actuator_pkg::*;
#(
    parameter int               NUM_CH          = 4,
    parameter int               DATA_W          = 32,
    parameter int               CNT_W           = 24,
    parameter logic [CNT_W-1:0] TIMEOUT_DEFAULT = '0,
    parameter logic [31:0]      VERSION         = VERSION_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    multi_actuator_if.slave   bus,
    input  logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] en,
    output logic              irq
);
    logic              wr;
    logic [2:0]        a;
    logic [NUM_CH-1:0] wd, start, abort, clr_d, clr_e, done_set, err_set, done_r, err_r, irq_en;
    logic [CNT_W-1:0]  timeout;
    logic [DATA_W-1:0] rd_mux;
    assign wr    = ~bus.write_n;
    assign a     = bus.address;
    assign wd    = bus.writedata[NUM_CH-1:0];
    assign start = (wr && a == REG_CTRL)  ? wd : '0;
    assign abort = (wr && a == REG_ABORT) ? wd : '0;
    assign clr_d = (wr && a == REG_DONE)  ? wd : '0;
    assign clr_e = (wr && a == REG_ERR)   ? wd : '0;
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        actuator_channel #(.CNT_W(CNT_W)) u_ch (
            .clk(clk), .reset(reset), .start(start[g]), .abort(abort[g]), .done(done[g]),
            .timeout(timeout), .en(en[g]), .done_set(done_set[g]), .err_set(err_set[g])
        );
    end
    always_comb begin
        rd_mux = (a == REG_CTRL || a == REG_STATUS) ? DATA_W'(en) :
                 a == REG_DONE    ? DATA_W'(done_r) :
                 a == REG_ERR     ? DATA_W'(err_r) :
                 a == REG_IRQ_EN  ? DATA_W'(irq_en) :
                 a == REG_TIMEOUT ? DATA_W'(timeout) :
                 a == REG_VERSION ? DATA_W'(VERSION) : '0;
    end
    // a hardware set in the same cycle as a W1C of that bit keeps the flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r       <= '0;
            err_r        <= '0;
            irq_en       <= '0;
            timeout      <= TIMEOUT_DEFAULT;
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            done_r  <= (done_r & ~clr_d) | done_set;
            err_r   <= (err_r & ~clr_e) | err_set;
            irq_en  <= (wr && a == REG_IRQ_EN) ? wd : irq_en;
            timeout <= (wr && a == REG_TIMEOUT) ? bus.writedata[CNT_W-1:0] : timeout;
            bus.readdata <= bus.read_n ? bus.readdata : rd_mux;
            irq     <= |((done_r | err_r) & irq_en);
        end
    end
endmodule

// File: tb/tb_multi_actuator.sv
// tb_multi_actuator: randomized scoreboard bench against a cycle-indexed reference model
module tb_multi_actuator;
    localparam int NC = 4;
    localparam int MAXC = 24'hFF_FFFF;
    localparam logic [31:0] VER = 32'h0001_0002;
    typedef struct {
        logic [NC-1:0] en;
        logic          irq;
        logic [31:0]   rd;
    } exp_t;
    logic clk = 1'b0, reset = 1'b1;
    logic [NC-1:0] done = '0, en;
    logic irq;
    multi_actuator_if #(.DATA_W(32)) bus();
    multi_actuator #(.NUM_CH(NC), .DATA_W(32), .CNT_W(24)) dut (
        .clk(clk), .reset(reset), .bus(bus), .done(done), .en(en), .irq(irq)
    );
    always #5 clk = ~clk;
    exp_t q[$];
    int total = 0, bad = 0;
    bit run[NC];
    int t0[NC];
    int cyc = 0, tmo = 0;
    logic [NC-1:0] dfl = '0, efl = '0, ien = '0;
    logic [31:0] rd_exp = '0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask
    function automatic logic [NC-1:0] run_mask();
        logic [NC-1:0] m = '0;
        for (int i = 0; i < NC; i++) m[i] = run[i];
        return m;
    endfunction
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("en", 32'(en), 32'(e.en));
            check("irq", 32'(irq), 32'(e.irq));
            check("readdata", bus.readdata, e.rd);
        end
    end
    // called at a negedge: drives inputs for the next posedge and predicts the outputs after it
    task automatic step(input logic w, input logic [2:0] a, input logic [31:0] d, input logic r, input logic [NC-1:0] dn);
        logic [NC-1:0] ds = '0, es = '0, cl;
        logic ie;
        int c;
        bus.write_n = ~w; bus.address = a; bus.writedata = d; bus.read_n = ~r; done = dn;
        if (r)
            rd_exp = a <= 3'd1 ? 32'(run_mask()) : a == 3'd2 ? 32'(dfl) : a == 3'd3 ? 32'(efl) :
                     a == 3'd4 ? 32'(ien) : a == 3'd5 ? 32'(tmo) : a == 3'd7 ? VER : 32'd0;
        ie = |((dfl | efl) & ien);
        cyc++;
        for (int i = 0; i < NC; i++) begin
            if (run[i]) begin
                c = cyc - t0[i] - 1;
                if (c > MAXC) c = MAXC;
                if (dn[i]) begin run[i] = 0; ds[i] = 1; end
                else if (w && a == 3'd6 && d[i]) run[i] = 0;
                else if (tmo != 0 && c == tmo - 1) begin run[i] = 0; es[i] = 1; end
            end else if (w && a == 3'd0 && d[i]) begin
                run[i] = 1; t0[i] = cyc;
            end
        end
        cl = (w && a == 3'd2) ? d[NC-1:0] : '0;
        dfl = (dfl & ~cl) | ds;
        cl = (w && a == 3'd3) ? d[NC-1:0] : '0;
        efl = (efl & ~cl) | es;
        if (w && a == 3'd4) ien = d[NC-1:0];
        if (w && a == 3'd5) tmo = int'(d & 32'h00FF_FFFF);
        q.push_back('{en: run_mask(), irq: ie, rd: rd_exp});
        @(negedge clk);
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d); step(1, a, d, 0, '0); endtask
    task automatic rd(input logic [2:0] a); step(0, a, 0, 1, '0); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0); endtask
    task automatic do_reset();
        bus.write_n = 1; bus.read_n = 1; done = '0;
        reset = 1;
        #1;
        check("async_en", 32'(en), 0);
        check("async_irq", 32'(irq), 0);
        check("async_readdata", bus.readdata, 0);
        for (int i = 0; i < NC; i++) run[i] = 0;
        dfl = '0; efl = '0; ien = '0; tmo = 0; rd_exp = '0;
        cyc++;
        q.push_back('{en: '0, irq: 1'b0, rd: 32'd0});
        @(negedge clk);
        reset = 0;
    endtask
    initial begin
        logic [31:0] r;
        logic [2:0] a;
        bus.write_n = 1; bus.read_n = 1; bus.address = 0; bus.writedata = 0;
        for (int i = 0; i < NC; i++) begin run[i] = 0; t0[i] = 0; end
        repeat (2) @(negedge clk);
        check("reset_en", 32'(en), 0);
        check("reset_irq", 32'(irq), 0);
        check("reset_readdata", bus.readdata, 0);
        reset = 0;
        rd(7); rd(1); rd(2); rd(3); rd(4); rd(5); idle(1);
        wr(0, 32'h5); rd(1); idle(2);
        step(0, 0, 0, 0, 4'b0100); rd(2);
        wr(4, 4); idle(2); wr(2, 4); idle(2);
        wr(5, 10); wr(0, 2); idle(14); rd(3); rd(2); wr(3, 2);
        wr(0, 8); idle(2); step(1, 6, 8, 0, 4'b1000); rd(2); wr(2, 8);
        wr(5, 8); wr(0, 1); idle(4); wr(0, 1); idle(6); wr(3, 1);
        wr(5, 0); wr(4, 32'hF); wr(0, 32'hFFFF_FFFF); idle(3);
        do_reset(); rd(5); rd(1); idle(1);
        for (int n = 0; n < 4000; n++) begin
            if (n % 700 == 699) begin do_reset(); continue; end
            r = $urandom;
            a = 3'($urandom_range(0, 7));
            if (a == 3'd5) r = (r & 32'hFF00_0000) | 32'($urandom_range(0, 20));
            case ($urandom_range(0, 2))
                0: step(1, a, r, 0, 4'($urandom & $urandom & $urandom));
                1: step(0, a, 0, 1, 4'($urandom & $urandom & $urandom));
                default: step(0, a, 0, 0, 4'($urandom & $urandom & $urandom));
            endcase
        end
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
